pipereg_hs: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid entry. Successor to the plain enable/clear pipeline flops. Sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and on the memory request path. Downstream stalls back-pressure upstream through `ready` instead of a global enable.

---
 rtl/pipereg_hs_pkg.sv | 18 +
 rtl/pipereg_entry.sv | 38 +++
 rtl/pipereg_hs.sv | 123 ++++++++++++
 tb/tb_pipereg_hs.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipereg_hs_pkg.sv
// Shared definitions for the handshake pipeline register: datapath widths and occupancy encoding.
// The skid entry is enabled by defining PIPEREG_SKID_EN at build time (default: single entry).
package pipereg_hs_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IFID_W  = 2 * XLEN;
  localparam int unsigned IDEX_W  = 4 * XLEN;
  localparam int unsigned EXMEM_W = 3 * XLEN;
  localparam int unsigned MEMWB_W = 2 * XLEN;

  // Encoding doubles as the occupancy count driven on the count port.
  typedef enum logic [1:0] {
    OCC_EMPTY     = 2'd0,
    OCC_FULL      = 2'd1,
    OCC_FULL_SKID = 2'd2
  } occ_e;

endpackage

// File: rtl/pipereg_entry.sv
// Single payload register: async reset and synchronous clear to RESET_VAL, clear beats load.
module pipereg_entry
  import pipereg_hs_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = RESET_VAL;
    end else if (load_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipereg_hs.sv
// Valid/ready pipeline stage register with synchronous flush.
// Define PIPEREG_SKID_EN to add a skid entry and a registered in_ready.
module pipereg_hs
  import pipereg_hs_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  occ_e             state_q;
  occ_e             state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_ld;
  logic [WIDTH-1:0] main_d;

`ifdef PIPEREG_SKID_EN
  logic             skid_ld;
  logic             main_from_skid;
  logic [WIDTH-1:0] skid_q;

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready = (state_q != OCC_FULL_SKID);
  assign main_d   = main_from_skid ? skid_q : in_data;
`else
  assign in_ready = (state_q == OCC_EMPTY) | out_ready;
  assign main_d   = in_data;
`endif

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign count     = state_q;

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
`ifdef PIPEREG_SKID_EN
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
`endif
    case (state_q)
      OCC_EMPTY: begin
        if (in_fire) begin
          state_d = OCC_FULL;
          main_ld = 1'b1;
        end
      end
      OCC_FULL: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (out_fire) begin
          state_d = OCC_EMPTY;
`ifdef PIPEREG_SKID_EN
        end else if (in_fire) begin
          state_d = OCC_FULL_SKID;
          skid_ld = 1'b1;
`endif
        end
      end
`ifdef PIPEREG_SKID_EN
      OCC_FULL_SKID: begin
        if (out_fire) begin
          state_d        = OCC_FULL;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
`endif
      default: state_d = OCC_EMPTY;
    endcase
    // Flush drops any accepted input; an output fire this cycle has already completed.
    if (clear) begin
      state_d = OCC_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipereg_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (clear),
    .load_i  (main_ld),
    .d_i     (main_d),
    .q_o     (out_data)
  );

`ifdef PIPEREG_SKID_EN
  pipereg_entry #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (clear),
    .load_i  (skid_ld),
    .d_i     (in_data),
    .q_o     (skid_q)
  );
`endif

endmodule

// File: tb/tb_pipereg_hs.sv
// Bench for pipereg_hs (WIDTH=32): directed scenarios plus a queue scoreboard and occupancy model.
module tb_pipereg_hs;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb[$];
  int          mcount   = 0;
  logic        mon_en   = 1'b0;

  pipereg_hs #(
    .WIDTH     (32),
    .RESET_VAL (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and occupancy model, evaluated mid-cycle with inputs stable.
  always @(negedge clk) begin
    logic        exp_rdy;
    logic        in_f;
    logic        out_f;
    logic [31:0] exp_d;
    if (mon_en && !reset) begin
      chk("count", {30'd0, count}, mcount);
      chk("out_valid", {31'd0, out_valid}, {31'd0, (mcount != 0)});
`ifdef PIPEREG_SKID_EN
      exp_rdy = (mcount != 2);
`else
      exp_rdy = (mcount == 0) || out_ready;
`endif
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      out_f = (mcount != 0) && out_ready;
      in_f  = in_valid && exp_rdy;
      if (out_f) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          exp_d = sb.pop_front();
          chk("out_data", out_data, exp_d);
        end
      end
      if (clear) begin
        sb.delete();
        mcount = 0;
      end else begin
        if (in_f) sb.push_back(in_data);
        mcount = mcount + (in_f ? 1 : 0) - (out_f ? 1 : 0);
      end
    end
  end

  initial begin
    logic took;
    logic r0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) step();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", {30'd0, count}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Async reset while holding a beat.
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    step();
    chk("full_data", out_data, 32'hDEADBEEF);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 0);
    chk("async_out_data", out_data, 0);
    chk("async_count", {30'd0, count}, 0);
    chk("async_in_ready", {31'd0, in_ready}, 1);
    sb.delete();
    mcount = 0;
    step();
    reset = 1'b0;
    step();
    mon_en = 1'b1;

    // Streaming with no bubbles.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      chk("stream_valid", {31'd0, out_valid}, 1);
      chk("stream_data", out_data, i);
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Back-pressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
`ifdef PIPEREG_SKID_EN
    chk("bp_count", {30'd0, count}, 2);
    in_valid = 1'b0;
`else
    chk("bp_count", {30'd0, count}, 1);
`endif
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_data", out_data, 32'hA);
    step();
    chk("bp_hold", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_second", out_data, 32'hB);
    repeat (2) step();

    // Clear colliding with an input fire.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    step();
    in_data = 32'h6;
    clear   = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", {31'd0, out_valid}, 0);
    chk("clr_out_data", out_data, 0);
    chk("clr_count", {30'd0, count}, 0);
    out_ready = 1'b1;
    repeat (3) step();

    // Random traffic obeying the upstream hold rule.
    took = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 63) == 0);
      if (!in_valid || took) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      #2;
      took = in_valid && in_ready;
      step();
    end
    clear = 1'b0;

`ifdef PIPEREG_SKID_EN
    // in_ready must only move on clock edges.
    took = 1'b1;
    for (int c = 0; c < 40; c++) begin
      r0 = in_ready;
      if (!in_valid || took) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      #1;
      out_ready = ~out_ready;
      #1;
      chk("skid_rdy_stable", {31'd0, in_ready}, {31'd0, r0});
      took = in_valid && in_ready;
      step();
    end
`endif

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", sb.size(), 0);
    chk("drain_count", {30'd0, count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
